// File: rtl/burst_arbiter_ctrl_pkg.sv
// burst_arbiter_ctrl_pkg: shared arbiter types for the burst arbiter controller
package burst_arbiter_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;
endpackage

// File: rtl/burst_arbiter_ctrl_picker.sv
// rr_priority_picker: combinational round-robin pick starting one past the last winner
module rr_priority_picker import burst_arbiter_ctrl_pkg::*; #(
    parameter int NUM_REQ      = 4,
    parameter int SELECT_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [SELECT_WIDTH-1:0] i_last_winner,
    output logic [NUM_REQ-1:0]      o_onehot,
    output logic [SELECT_WIDTH-1:0] o_index,
    output logic                    o_any
);
    logic [SELECT_WIDTH-1:0] w_pos;
    // Walk offsets from farthest to nearest so the nearest requester overwrites the result.
    always_comb begin
        o_index = '0;
        w_pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = i_last_winner + SELECT_WIDTH'(k + 1);
            if (i_req[w_pos]) o_index = w_pos;
        end
    end
    assign o_any    = |i_req;
    assign o_onehot = o_any ? (NUM_REQ'(1) << o_index) : '0;
endmodule

// File: rtl/burst_arbiter_ctrl.sv
// burst_arbiter_ctrl: round-robin burst arbiter with beat counting, done/abort pulses
module burst_arbiter_ctrl import burst_arbiter_ctrl_pkg::*; #(
    parameter int NUM_REQ      = 4,
    parameter int SELECT_WIDTH = $clog2(NUM_REQ),
    parameter int LEN_WIDTH    = 8
) (
    input  logic                           ap_clk,
    input  logic                           areset,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
    input  logic                           beat,
    output logic [NUM_REQ-1:0]             grant,
    output logic [SELECT_WIDTH-1:0]        select,
    output logic                           valid,
    output logic                           done,
    output logic                           abort
);
    arb_state_t              r_state;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [SELECT_WIDTH-1:0] r_last;
    logic [NUM_REQ-1:0]      w_onehot;
    logic [SELECT_WIDTH-1:0] w_idx;
    logic                    w_any;
    logic [LEN_WIDTH-1:0]    w_len;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .SELECT_WIDTH(SELECT_WIDTH)) u_picker (
        .i_req(req), .i_last_winner(r_last),
        .o_onehot(w_onehot), .o_index(w_idx), .o_any(w_any)
    );

    assign w_len = req_len[w_idx*LEN_WIDTH +: LEN_WIDTH];

    // GAP is the single zero-grant cycle; it may arbitrate so bursts are separated by exactly one idle cycle.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= SELECT_WIDTH'(NUM_REQ - 1);
            grant   <= '0;
            select  <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (r_state)
                ST_BUSY: begin
                    if (beat && r_cnt == LEN_WIDTH'(1)) begin
                        done    <= 1'b1;
                        grant   <= '0;
                        valid   <= 1'b0;
                        r_state <= ST_GAP;
                    end else if (!req[select]) begin
                        abort   <= 1'b1;
                        grant   <= '0;
                        valid   <= 1'b0;
                        r_state <= ST_GAP;
                    end else if (beat) begin
                        r_cnt <= r_cnt - LEN_WIDTH'(1);
                    end
                end
                default: begin
                    if (enable && w_any) begin
                        r_state <= ST_BUSY;
                        grant   <= w_onehot;
                        select  <= w_idx;
                        valid   <= 1'b1;
                        r_last  <= w_idx;
                        r_cnt   <= (w_len == '0) ? LEN_WIDTH'(1) : w_len;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
